// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI master that drives the SPI-slave/RAM subsystem:
// opcodes, frame geometry and the master FSM state encoding.
package spi_ram_pkg;

   localparam int FRAME_BITS = 10;
   localparam int DATA_BITS  = 8;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SEL   = 3'd1,
      ST_SHIFT = 3'd2,
      ST_TURN  = 3'd3,
      ST_RECV  = 3'd4,
      ST_GAP   = 3'd5
   } state_t;

endpackage

// File: rtl/spi_ram_master.sv
// SPI initiator: turns one parallel RAM command into one SPI frame on
// SS_n/MOSI and, for read-data frames, returns the byte sampled from MISO.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready
// are both high; req_ready is high only while IDLE, so the requester may hold
// req_valid (and change req_op/req_data) freely while a frame is in flight.
module spi_ram_master
   import spi_ram_pkg::*;
#(
   parameter int RD_LATENCY = 2,
   parameter int GAP_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_op,
   input  logic [7:0] req_data,
   output logic       resp_valid,
   output logic [7:0] resp_data,
   output logic       busy,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO,
   output state_t     state
);

   localparam logic [3:0] LAST_BIT  = 4'(FRAME_BITS - 1);
   localparam logic [3:0] LAST_RX   = 4'(DATA_BITS - 1);
   localparam logic [3:0] TURN_LOAD = 4'(RD_LATENCY - 1);
   localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES - 1);

   state_t                   state_q;
   logic [FRAME_BITS-1:0]    frame_q;    // command bits still to send, MSB next
   logic                     rd_q;       // frame in flight is a read-data frame
   logic [3:0]               bit_cnt_q;  // bits sent in SHIFT / bits taken in RECV
   logic [3:0]               wait_cnt_q; // remaining TURN or GAP cycles minus one
   logic [DATA_BITS-2:0]     rx_q;       // first seven MISO bits of the reply
   logic                     ss_n_q;
   logic                     mosi_q;
   logic                     ready_q;
   logic                     resp_valid_q;
   logic [DATA_BITS-1:0]     resp_data_q;

   // Frame sequencer: all pin and response outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         frame_q      <= '0;
         rd_q         <= 1'b0;
         bit_cnt_q    <= '0;
         wait_cnt_q   <= '0;
         rx_q         <= '0;
         ss_n_q       <= 1'b1;
         mosi_q       <= 1'b0;
         ready_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               ready_q <= 1'b1;
               if (req_valid && ready_q) begin
                  // Read-data carries no payload; its data field goes out as zeros.
                  frame_q <= (req_op == OP_RD_DATA) ? {OP_RD_DATA, 8'h00} : {req_op, req_data};
                  rd_q    <= (req_op == OP_RD_DATA);
                  ready_q <= 1'b0;
                  ss_n_q  <= 1'b0;
                  mosi_q  <= req_op[1];
                  state_q <= ST_SEL;
               end
            end
            ST_SEL: begin
               // The select cycle repeats the first frame bit, then SHIFT sends all ten.
               mosi_q    <= frame_q[FRAME_BITS-1];
               bit_cnt_q <= '0;
               state_q   <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (bit_cnt_q == LAST_BIT) begin
                  mosi_q <= 1'b0;
                  if (rd_q) begin
                     wait_cnt_q <= TURN_LOAD;
                     state_q    <= ST_TURN;
                  end else begin
                     ss_n_q     <= 1'b1;
                     wait_cnt_q <= GAP_LOAD;
                     state_q    <= ST_GAP;
                  end
               end else begin
                  mosi_q    <= frame_q[FRAME_BITS-2];
                  frame_q   <= {frame_q[FRAME_BITS-2:0], 1'b0};
                  bit_cnt_q <= bit_cnt_q + 4'd1;
               end
            end
            ST_TURN: begin
               if (wait_cnt_q == 4'd0) begin
                  bit_cnt_q <= '0;
                  state_q   <= ST_RECV;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 4'd1;
               end
            end
            ST_RECV: begin
               rx_q <= {rx_q[DATA_BITS-3:0], MISO};
               if (bit_cnt_q == LAST_RX) begin
                  resp_data_q  <= {rx_q, MISO};
                  resp_valid_q <= 1'b1;
                  ss_n_q       <= 1'b1;
                  wait_cnt_q   <= GAP_LOAD;
                  state_q      <= ST_GAP;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 4'd1;
               end
            end
            ST_GAP: begin
               if (wait_cnt_q == 4'd0) begin
                  ready_q <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 4'd1;
               end
            end
            default: begin
               ss_n_q  <= 1'b1;
               mosi_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign busy       = (state_q != ST_IDLE);
   assign SS_n       = ss_n_q;
   assign MOSI       = mosi_q;
   assign state      = state_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: a default build (RD_LATENCY=2, GAP_CYCLES=2) and a
// short build (1,1), each talking to a behavioural SPI RAM slave.
module tb_spi_ram_master;
   import spi_ram_pkg::*;

   logic            clk = 1'b0;
   logic [1:0]      rst_v = 2'b11;
   logic [1:0]      req_valid_v = '0;
   logic [1:0][1:0] req_op_v = '0;
   logic [1:0][7:0] req_data_v = '0;
   logic [1:0]      miso_v = '0;
   logic [1:0]      req_ready_v, resp_valid_v, busy_v, ss_n_v, mosi_v;
   logic [1:0][7:0] resp_data_v;
   state_t          st0, st1;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   // reference model of the master, per instance
   bit         m_chk[2], m_act[2], m_ready[2], m_rd[2];
   int         m_k[2];
   logic [9:0] m_frame[2];
   logic [7:0] m_rdata[2], m_exp[2], m_addr[2], m_rdaddr[2];
   logic [7:0] m_mem[2][256];
   // behavioural SPI RAM slave, per instance
   int          s_cnt[2];
   bit          s_rd[2];
   logic [10:0] s_bits[2];
   logic [7:0]  s_addr[2], s_rdaddr[2], s_byte[2];
   logic [7:0]  s_mem[2][256];
   logic        s_next[2];
   // pin monitor measurements
   int          run_len[2], last_run[2], gap_run[2], last_gap[2];
   int          rv_cnt[2], acc_cyc[2], rv_lat[2];
   logic [10:0] run_bits[2], last_bits[2];

   spi_ram_master #(.RD_LATENCY(2), .GAP_CYCLES(2)) dut0 (
      .clk(clk), .rst(rst_v[0]), .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
      .req_op(req_op_v[0]), .req_data(req_data_v[0]), .resp_valid(resp_valid_v[0]),
      .resp_data(resp_data_v[0]), .busy(busy_v[0]), .SS_n(ss_n_v[0]), .MOSI(mosi_v[0]),
      .MISO(miso_v[0]), .state(st0));

   spi_ram_master #(.RD_LATENCY(1), .GAP_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst_v[1]), .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
      .req_op(req_op_v[1]), .req_data(req_data_v[1]), .resp_valid(resp_valid_v[1]),
      .resp_data(resp_data_v[1]), .busy(busy_v[1]), .SS_n(ss_n_v[1]), .MOSI(mosi_v[1]),
      .MISO(miso_v[1]), .state(st1));

   function automatic int rdl_of(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   function automatic int gap_of(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   // frame length with SS_n low, from the frame type
   function automatic int low_len(input int i, input bit rd);
      return rd ? (19 + rdl_of(i)) : 11;
   endfunction

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s inst%0d: got %0h expected %0h at cycle %0d", nm, i, act, exp, cyc);
      end
   endtask

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 256; j++) begin
            m_mem[i][j] = 8'(j) ^ 8'hC3;
            s_mem[i][j] = 8'(j) ^ 8'hC3;
         end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- model, slave and monitor (rising edge) ----------------
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         // monitor of the DUT pins during the cycle that just ended
         if (req_valid_v[i] && req_ready_v[i]) acc_cyc[i] = cyc;
         if (resp_valid_v[i]) begin
            rv_cnt[i]++;
            rv_lat[i] = cyc - acc_cyc[i];
         end
         if (!ss_n_v[i]) begin
            if (run_len[i] < 11) run_bits[i] = {run_bits[i][9:0], mosi_v[i]};
            run_len[i]++;
            gap_run[i] = 0;
         end else begin
            if (run_len[i] > 0) begin
               last_run[i]  = run_len[i];
               last_bits[i] = run_bits[i];
               run_len[i]   = 0;
               run_bits[i]  = '0;
            end
            if (busy_v[i]) gap_run[i]++;
            else if (gap_run[i] > 0) begin
               last_gap[i] = gap_run[i];
               gap_run[i]  = 0;
            end
         end

         // slave: collect 11 bits while selected, then act on the frame
         if (!ss_n_v[i]) begin
            s_cnt[i]++;
            if (s_cnt[i] <= 11) s_bits[i] = {s_bits[i][9:0], mosi_v[i]};
            if (s_cnt[i] == 11) begin
               case (s_bits[i][9:8])
                  2'b00: s_addr[i] = s_bits[i][7:0];
                  2'b01: s_mem[i][s_addr[i]] = s_bits[i][7:0];
                  2'b10: s_rdaddr[i] = s_bits[i][7:0];
                  default: begin
                     s_rd[i]   = 1'b1;
                     s_byte[i] = s_mem[i][s_rdaddr[i]];
                  end
               endcase
            end
         end else begin
            s_cnt[i] = 0;
            s_rd[i]  = 1'b0;
         end
         // reply bits occupy frame cycles 12+RDL .. 19+RDL, noise elsewhere
         if (s_rd[i] && (s_cnt[i] + 1 >= 12 + rdl_of(i)) && (s_cnt[i] + 1 <= 19 + rdl_of(i)))
            s_next[i] = s_byte[i][19 + rdl_of(i) - (s_cnt[i] + 1)];
         else
            s_next[i] = 1'($urandom_range(0, 1));

         // master model, counted in cycles since the accepting edge
         if (rst_v[i]) begin
            m_chk[i]   = 1'b1;
            m_act[i]   = 1'b0;
            m_ready[i] = 1'b0;
            m_rdata[i] = 8'h00;
         end else if (m_act[i]) begin
            m_k[i]++;
            if (m_rd[i] && m_k[i] == low_len(i, m_rd[i]) + 1) m_rdata[i] = m_exp[i];
            if (m_k[i] > low_len(i, m_rd[i]) + gap_of(i)) begin
               m_act[i]   = 1'b0;
               m_ready[i] = 1'b1;
            end
         end else if (req_valid_v[i] && m_ready[i]) begin
            m_act[i]   = 1'b1;
            m_k[i]     = 1;
            m_ready[i] = 1'b0;
            m_rd[i]    = (req_op_v[i] == 2'b11);
            m_frame[i] = m_rd[i] ? 10'b11_0000_0000 : {req_op_v[i], req_data_v[i]};
            case (req_op_v[i])
               2'b00: m_addr[i] = req_data_v[i];
               2'b01: m_mem[i][m_addr[i]] = req_data_v[i];
               2'b10: m_rdaddr[i] = req_data_v[i];
               default: m_exp[i] = m_mem[i][m_rdaddr[i]];
            endcase
         end else begin
            m_ready[i] = 1'b1;
         end
      end
      cyc++;
   end

   // ---------------- compare (falling edge) ----------------
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         miso_v[i] = s_next[i];
         if (m_chk[i]) begin
            int  l, k;
            bit  e_ss, e_mosi, e_rv;
            l      = low_len(i, m_rd[i]);
            k      = m_k[i];
            e_ss   = !(m_act[i] && k <= l);
            e_mosi = 1'b0;
            if (m_act[i] && k == 1) e_mosi = m_frame[i][9];
            else if (m_act[i] && k >= 2 && k <= 11) e_mosi = m_frame[i][11 - k];
            e_rv   = m_act[i] && m_rd[i] && (k == l + 1);
            chk("ss_n", i, 32'(ss_n_v[i]), 32'(e_ss));
            chk("mosi", i, 32'(mosi_v[i]), 32'(e_mosi));
            chk("busy", i, 32'(busy_v[i]), 32'(m_act[i]));
            chk("req_ready", i, 32'(req_ready_v[i]), 32'(m_ready[i]));
            chk("resp_valid", i, 32'(resp_valid_v[i]), 32'(e_rv));
            chk("resp_data", i, 32'(resp_data_v[i]), 32'(m_rdata[i]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input int i, input logic [1:0] op, input logic [7:0] d, input bit hold);
      bit ok;
      @(posedge clk); #1;
      req_valid_v[i] = 1'b1;
      req_op_v[i]    = op;
      req_data_v[i]  = d;
      ok = 1'b0;
      for (int c = 0; c < 300 && !ok; c++) begin
         @(posedge clk);
         if (req_ready_v[i]) ok = 1'b1;
      end
      chk("accept_timeout", i, 32'(ok), 32'd1);
      #1;
      if (!hold) req_valid_v[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 300 && !ok; c++) begin
         @(negedge clk);
         if (!busy_v[i] && req_ready_v[i]) ok = 1'b1;
      end
      chk("idle_timeout", i, 32'(ok), 32'd1);
      @(posedge clk); #1;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int rv0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ss_n", 0, 32'(ss_n_v[0]), 32'd1);
      chk("rst_mosi", 0, 32'(mosi_v[0]), 32'd0);
      chk("rst_ready", 0, 32'(req_ready_v[0]), 32'd0);
      chk("rst_resp", 0, 32'(resp_data_v[0]), 32'h00);
      chk("rst_state", 0, 32'(st0), 32'(ST_IDLE));
      @(posedge clk); #1;
      rst_v = 2'b00;

      // write-addr 0x02
      send(0, 2'b00, 8'h02, 1'b0);
      wait_idle(0);
      chk("wa_bits", 0, 32'(last_bits[0]), 32'(11'b000_0000_0010));
      chk("wa_len", 0, last_run[0], 11);
      chk("wa_gap", 0, last_gap[0], 2);

      // write-data 0xAB into address 2
      send(0, 2'b01, 8'hAB, 1'b0);
      wait_idle(0);
      chk("wd_bits", 0, 32'(last_bits[0]), 32'(11'b001_1010_1011));
      chk("slave_mem2", 0, 32'(s_mem[0][2]), 32'hAB);

      // read-addr 0x02 then read-data
      rv0 = rv_cnt[0];
      send(0, 2'b10, 8'h02, 1'b0);
      wait_idle(0);
      send(0, 2'b11, 8'h5F, 1'b0);
      wait_idle(0);
      chk("rd_pulses", 0, rv_cnt[0] - rv0, 1);
      chk("rd_byte", 0, 32'(resp_data_v[0]), 32'hAB);
      chk("rd_len", 0, last_run[0], 21);
      chk("rd_bits", 0, 32'(last_bits[0]), 32'(11'b111_0000_0000));
      chk("rd_latency", 0, rv_lat[0], 22);

      // request held valid across two frames, inputs change after accept
      send(0, 2'b00, 8'h11, 1'b1);
      send(0, 2'b01, 8'h77, 1'b0);
      chk("hold_f1_bits", 0, 32'(last_bits[0]), 32'(11'b000_0001_0001));
      wait_idle(0);
      chk("hold_f2_bits", 0, 32'(last_bits[0]), 32'(11'b001_0111_0111));
      chk("slave_mem11", 0, 32'(s_mem[0][8'h11]), 32'h77);

      // reset during cycle 6 of a read-data frame
      rv0 = rv_cnt[0];
      send(0, 2'b11, 8'h00, 1'b0);
      repeat (5) @(posedge clk);
      #1 rst_v[0] = 1'b1;
      @(posedge clk); #1;
      rst_v[0] = 1'b0;
      chk("abort_ss_n", 0, 32'(ss_n_v[0]), 32'd1);
      chk("abort_busy", 0, 32'(busy_v[0]), 32'd0);
      chk("abort_rv", 0, 32'(resp_valid_v[0]), 32'd0);
      send(0, 2'b00, 8'h05, 1'b0);
      wait_idle(0);
      chk("after_abort_bits", 0, 32'(last_bits[0]), 32'(11'b000_0000_0101));
      chk("abort_no_resp", 0, rv_cnt[0] - rv0, 0);

      // short build: back-to-back frames, read back 0x5A
      send(1, 2'b00, 8'h40, 1'b1);
      send(1, 2'b01, 8'h5A, 1'b1);
      send(1, 2'b10, 8'h40, 1'b1);
      chk("short_gap", 1, last_gap[1], 1);
      send(1, 2'b11, 8'h00, 1'b0);
      wait_idle(1);
      chk("short_byte", 1, 32'(resp_data_v[1]), 32'h5A);
      chk("short_len", 1, last_run[1], 20);
      chk("short_latency", 1, rv_lat[1], 21);

      repeat (4) @(posedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_ram_master.md
Name: spi_ram_master

Overview:
- SPI initiator for the SPI-slave/RAM subsystem: drives SS_n and MOSI, samples MISO.
- Converts one parallel RAM command per request into a single SPI frame: write-address, write-data, read-address or read-data.
- For read-data frames it captures the 8-bit byte the slave returns and presents it on a response port.
- Sits between the host/controller logic and the SPI pins of the slave/RAM top module, sharing its single clock.

Parameters:
- RD_LATENCY, 2, clk cycles between the last command bit and the first MISO sample on read-data frames (1..15).
- GAP_CYCLES, 2, minimum clk cycles SS_n stays high between frames (1..15).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  1  command request valid.
- req_ready  output  1  master can accept a request this cycle.
- req_op  input  2  00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
- req_data  input  8  address/data byte; ignored for op 11.
- resp_valid  output  1  one-cycle pulse, read byte available.
- resp_data  output  8  byte returned by slave; held until next resp_valid.
- busy  output  1  a frame or inter-frame gap is in progress.
- SS_n  output  1  slave select, active-low.
- MOSI  output  1  serial data to slave, MSB first.
- MISO  input  1  serial data from slave, MSB first.

Behaviour:
- Reset values (rst=1 at a clock edge): SS_n=1, MOSI=0, req_ready=0 during reset and 1 from the first cycle after it, resp_valid=0, resp_data=0x00, busy=0, state=IDLE.
- Reset mid-frame aborts the frame: SS_n=1 on the next edge, no resp_valid.
- Handshake: request accepted on a cycle with req_valid && req_ready.
  - req_ready=1 only in IDLE.
  - On accept, latch frame[9:0] = {req_op, req_data}, or {2'b11, 8'h00} for op 11.
- FSM states: IDLE, SEL, SHIFT, TURN, RECV, GAP.
- Timing, with accept at cycle 0:
  - IDLE -> SEL on accept.
  - SEL, cycle 1: SS_n=0, MOSI=frame[9] (the slave's read/write select bit).
  - SHIFT, cycles 2..11: MOSI=frame[9..0], one bit per cycle, via a 4-bit bit counter.
  - After SHIFT: op 11 -> TURN; other ops -> GAP.
  - TURN: SS_n=0, MOSI=0, held RD_LATENCY cycles.
  - RECV: SS_n=0, MOSI=0, MISO sampled on 8 consecutive edges into a shift register, MSB first. On the 8th sample, resp_data is updated and resp_valid=1 in the following cycle. Then -> GAP.
  - GAP: SS_n=1, MOSI=0, held GAP_CYCLES cycles, then -> IDLE.
- Frame lengths: write/read-addr frame has SS_n low for 11 cycles; read-data frame has SS_n low for 11+RD_LATENCY+8 cycles.
- busy=1 in every state except IDLE.
- resp_valid and a new accept can never coincide, because GAP follows RECV.
- req_data/req_op changes after accept have no effect on the frame in flight.
- MISO is ignored outside RECV.

Decomposition:
- Shared package spi_ram_pkg:
  - opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
  - FSM state encoding.
  - FRAME_BITS=10, DATA_BITS=8.
- No sub-module required. The FSM, bit/wait counters and the two shift registers live in one module.

Test Plan:
- Reset, then write-addr 0x02 -> SS_n low for 11 cycles; MOSI = 0,0,0,0,0,0,0,0,0,1,0; then SS_n=1 for 2 cycles; req_ready returns to 1.
- Write-data 0xAB after the previous frame -> MOSI = 0,0,1,1,0,1,0,1,0,1,1; slave model writes mem[2]=0xAB.
- Read-addr 0x02, then read-data, against a slave model returning 0xAB at RD_LATENCY=2 -> resp_valid pulses exactly once, resp_data=0xAB, 21 SS_n-low cycles.
- req_valid held high during a frame -> second request accepted only when IDLE returns; no bits of frame 1 corrupted.
- rst asserted at cycle 6 of a read-data frame -> SS_n=1, busy=0, resp_valid=0 next cycle; a subsequent write-addr 0x05 frame is bit-exact.
- RD_LATENCY=1, GAP_CYCLES=1 build, read-data with slave returning 0x5A -> first MISO sample at cycle 13, resp_data=0x5A, SS_n high exactly 1 cycle before the next accept.
